// File: rtl/secuenciador_tabla_if.sv
// Bundle of front-end and datapath signals for the truth-table sequencer.
//   start, abort : sweep control from the front end
//   vec_out      : input vector applied to the combinational datapath
//   dut_in       : datapath outputs sampled once per vector
//   busy, done   : sweep status; done is a one-cycle completion pulse
//   tabla        : captured table, entry i at [i*N_OUT +: N_OUT]
//   err, err_idx : sticky mismatch flag and first mismatching vector
// master = front end / datapath side, slave = the sequencer.
interface secuenciador_tabla_if #(
   parameter int N_IN  = 3,
   parameter int N_OUT = 2
);
   localparam int TW = (2 ** N_IN) * N_OUT;

   logic            start;
   logic            abort;
   logic [N_IN-1:0] vec_out;
   logic [N_OUT-1:0] dut_in;
   logic            busy;
   logic            done;
   logic [TW-1:0]   tabla;
   logic            err;
   logic [N_IN-1:0] err_idx;

   modport master (
      output start, abort, dut_in,
      input  vec_out, busy, done, tabla, err, err_idx
   );

   modport slave (
      input  start, abort, dut_in,
      output vec_out, busy, done, tabla, err, err_idx
   );
endinterface

// File: rtl/secuenciador_tabla.sv
// Exhaustive truth-table sequencer: walks vec_out through every input vector,
// holds each one SETTLE+1 cycles, samples the datapath outputs into tabla and
// compares each entry against EXPECTED, latching the first mismatching index.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : secuenciador_tabla_if.slave (control, datapath and result signals)
//
// state | meaning
// IDLE  | waiting for start; results from the last sweep held
// HOLD  | vector vec_out applied; counter counts settle cycles, sample at 0
// DONE  | one-cycle done pulse; start ignored here
module secuenciador_tabla #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 1,
   parameter logic [(2 ** N_IN) * N_OUT - 1:0] EXPECTED = 16'hE99C
) (
   input  logic                 clk,
   input  logic                 rst_n,
   secuenciador_tabla_if.slave  bus
);
   localparam int TW = (2 ** N_IN) * N_OUT;
   localparam logic [N_IN-1:0] LAST = {N_IN{1'b1}};
   localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

   state_t           state;
   logic [3:0]       cnt;
   logic [N_IN-1:0]  vec;
   logic             busy;
   logic             done;
   logic [TW-1:0]    tabla;
   logic             err;
   logic [N_IN-1:0]  err_idx;
   logic [N_OUT-1:0] exp_entry;

   assign exp_entry = EXPECTED[vec * N_OUT +: N_OUT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         vec     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         tabla   <= '0;
         err     <= 1'b0;
         err_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (bus.start) begin
                  state   <= HOLD;
                  busy    <= 1'b1;
                  vec     <= '0;
                  cnt     <= SETTLE_CNT;
                  tabla   <= '0;
                  err     <= 1'b0;
                  err_idx <= '0;
               end
            end
            HOLD: begin
               // abort beats the sample edge: the pending entry is not written
               if (bus.abort) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  vec   <= '0;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  tabla[vec * N_OUT +: N_OUT] <= bus.dut_in;
                  if ((bus.dut_in != exp_entry) && !err) begin
                     err     <= 1'b1;
                     err_idx <= vec;
                  end
                  if (vec == LAST) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     vec   <= '0;
                  end else begin
                     vec <= vec + 1'b1;
                     cnt <= SETTLE_CNT;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
               vec   <= '0;
            end
         endcase
      end
   end

   assign bus.vec_out = vec;
   assign bus.busy    = busy;
   assign bus.done    = done;
   assign bus.tabla   = tabla;
   assign bus.err     = err;
   assign bus.err_idx = err_idx;
endmodule
